// File: rtl/ddr_app_pkg.sv
// Shared constants and helpers for the DDR app-interface responder.
// Command encodings and beat-address to RAM-word mapping.
package ddr_app_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ = 3'b001;
    localparam int unsigned ADDR_STRIDE = 8;

    function automatic logic [63:0] word_index(
        input logic [63:0] addr,
        input int unsigned depth_log2
    );
        logic [63:0] w;
        w = addr / 64'(ADDR_STRIDE);
        return w & ((64'd1 << depth_log2) - 64'd1);
    endfunction

endpackage

// File: rtl/ddr_app_responder_fifo.sv
// Small synchronous FIFO used for the write-command and write-data queues.
// Push is ignored when full, pop is ignored when empty.
module app_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr_app_responder.sv
// RAM-backed stand-in for the DDR memory-interface IP app port.
// Queued writes, fixed-latency reads, calibration delay and ready stalls.
module ddr_app_responder
    import ddr_app_pkg::*;
#(
    parameter int DDR_DATA_WIDTH   = 128,
    parameter int DDR_ADDR_WIDTH   = 28,
    parameter int MEM_DEPTH_LOG2   = 10,
    parameter int RD_LATENCY       = 4,
    parameter int CALIB_CYCLES     = 16,
    parameter int RDY_STALL_PERIOD = 0,
    parameter int WDF_STALL_PERIOD = 0,
    parameter int WQ_DEPTH         = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DDR_ADDR_WIDTH-1:0]   app_addr,
    input  logic [2:0]                  app_cmd,
    input  logic                        app_en,
    output logic                        app_rdy,
    input  logic [DDR_DATA_WIDTH-1:0]   app_wdf_data,
    input  logic [DDR_DATA_WIDTH/8-1:0] app_wdf_mask,
    input  logic                        app_wdf_wren,
    input  logic                        app_wdf_end,
    output logic                        app_wdf_rdy,
    output logic [DDR_DATA_WIDTH-1:0]   app_rd_data,
    output logic                        app_rd_data_valid,
    output logic                        init_calib_complete,
    output logic                        err_cmd,
    output logic                        err_wdf
);

    localparam int DW  = DDR_DATA_WIDTH;
    localparam int MW  = DDR_DATA_WIDTH / 8;
    localparam int AW  = MEM_DEPTH_LOG2;
    localparam int DLY = RD_LATENCY - 1;
    localparam int CCW = $clog2(CALIB_CYCLES + 1);
    localparam int QCW = $clog2(WQ_DEPTH) + 1;
    localparam int RSP = (RDY_STALL_PERIOD > 1) ? RDY_STALL_PERIOD : 2;
    localparam int RSW = $clog2(RSP);
    localparam int WSP = (WDF_STALL_PERIOD > 1) ? WDF_STALL_PERIOD : 2;
    localparam int WSW = $clog2(WSP);

    logic [CCW-1:0] calib_cnt;
    logic           calib;
    logic [RSW-1:0] rdy_cnt;
    logic [WSW-1:0] wdf_cnt;
    logic           rdy_stall;
    logic           wdf_stall;
    logic           is_wr;
    logic           is_rd;
    logic           is_bad;
    logic           cmd_acc;
    logic           hazard;
    logic [AW-1:0]  widx;
    logic           wcmd_full;
    logic           wcmd_empty;
    logic [QCW-1:0] wcmd_count;
    logic [AW-1:0]  wcmd_addr;
    logic           wdata_full;
    logic           wdata_empty;
    logic [QCW-1:0] wdata_count;
    logic [DW-1:0]  wq_data;
    logic [MW-1:0]  wq_mask;
    logic           commit;
    logic [DW-1:0]  ram [1 << AW];
    logic [DLY-1:0] rd_v;
    logic [AW-1:0]  rd_a [DLY];

    assign init_calib_complete = calib;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            calib_cnt <= '0;
            calib     <= 1'b0;
        end else if (!calib) begin
            if (calib_cnt == CCW'(CALIB_CYCLES - 1)) begin
                calib <= 1'b1;
            end
            calib_cnt <= calib_cnt + 1'b1;
        end
    end

    // Stall phase counters start together with calibration.
    always_ff @(posedge clk) begin
        if (!rst_n || !calib) begin
            rdy_cnt <= '0;
            wdf_cnt <= '0;
        end else begin
            rdy_cnt <= (rdy_cnt == RSW'(RSP - 1)) ? '0 : rdy_cnt + 1'b1;
            wdf_cnt <= (wdf_cnt == WSW'(WSP - 1)) ? '0 : wdf_cnt + 1'b1;
        end
    end

    assign rdy_stall = (RDY_STALL_PERIOD == 1) ||
                       ((RDY_STALL_PERIOD > 1) && (rdy_cnt == RSW'(RSP - 1)));
    assign wdf_stall = (WDF_STALL_PERIOD == 1) ||
                       ((WDF_STALL_PERIOD > 1) && (wdf_cnt == WSW'(WSP - 1)));

    always_comb begin
        is_wr  = 1'b0;
        is_rd  = 1'b0;
        is_bad = 1'b0;
        unique case (1'b1)
            (app_cmd == CMD_WRITE): is_wr  = 1'b1;
            (app_cmd == CMD_READ):  is_rd  = 1'b1;
            default:                is_bad = 1'b1;
        endcase
    end

    // Reads wait until every queued write has landed in RAM.
    assign hazard      = (wcmd_count != '0) && is_rd;
    assign app_rdy     = calib & ~rdy_stall & ~wcmd_full & ~hazard;
    assign app_wdf_rdy = calib & ~wdf_stall & ~wdata_full;
    assign cmd_acc     = app_en & app_rdy;
    assign widx        = AW'(word_index(64'(app_addr), AW));
    assign commit      = ~wcmd_empty & ~wdata_empty;

    app_sync_fifo #(
        .WIDTH (AW),
        .DEPTH (WQ_DEPTH)
    ) u_wcmd (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_acc & is_wr),
        .din   (widx),
        .pop   (commit),
        .dout  (wcmd_addr),
        .full  (wcmd_full),
        .empty (wcmd_empty),
        .count (wcmd_count)
    );

    app_sync_fifo #(
        .WIDTH (DW + MW),
        .DEPTH (WQ_DEPTH)
    ) u_wdata (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (app_wdf_wren & app_wdf_rdy),
        .din   ({app_wdf_data, app_wdf_mask}),
        .pop   (commit),
        .dout  ({wq_data, wq_mask}),
        .full  (wdata_full),
        .empty (wdata_empty),
        .count (wdata_count)
    );

    always_ff @(posedge clk) begin
        if (rst_n && commit) begin
            for (int b = 0; b < MW; b++) begin
                if (!wq_mask[b]) begin
                    ram[wcmd_addr][b*8 +: 8] <= wq_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 1; i < DLY; i++) begin
            rd_a[i] <= rd_a[i-1];
        end
        rd_a[0] <= widx;
        if (!rst_n) begin
            rd_v              <= '0;
            app_rd_data_valid <= 1'b0;
            app_rd_data       <= '0;
        end else begin
            for (int i = 1; i < DLY; i++) begin
                rd_v[i] <= rd_v[i-1];
            end
            rd_v[0]           <= cmd_acc & is_rd;
            app_rd_data_valid <= rd_v[DLY-1];
            if (rd_v[DLY-1]) begin
                app_rd_data <= ram[rd_a[DLY-1]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cmd <= 1'b0;
            err_wdf <= 1'b0;
        end else begin
            if (cmd_acc && is_bad) begin
                err_cmd <= 1'b1;
            end
            if (app_wdf_wren && (app_wdf_end != app_wdf_wren)) begin
                err_wdf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr_app_responder.sv
// Randomized self-checking bench for ddr_app_responder.
// A flat memory model predicts read data; read latency is checked per beat.
module tb_ddr_app_responder;

    localparam int RD_LAT = 4;
    localparam logic [2:0] WR = 3'b000;
    localparam logic [2:0] RD = 3'b001;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic         app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         init_calib_complete;
    logic         err_cmd;
    logic         err_wdf;

    int passed = 0;
    int total = 0;
    int cyc = 0;

    logic [127:0] model_mem [1024];
    logic [127:0] rd_q[$];
    int           rd_c[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (app_rd_data_valid === 1'b1) begin
            rd_q.push_back(app_rd_data);
            rd_c.push_back(cyc);
        end
    end

    ddr_app_responder #(
        .RDY_STALL_PERIOD (3),
        .WDF_STALL_PERIOD (5)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .init_calib_complete (init_calib_complete),
        .err_cmd             (err_cmd),
        .err_wdf             (err_wdf)
    );

    function automatic void model_write(input logic [27:0] a,
                                        input logic [127:0] d,
                                        input logic [15:0] m);
        int idx;
        idx = (int'(a) / 8) % 1024;
        for (int b = 0; b < 16; b++) begin
            if (!m[b]) model_mem[idx][b*8 +: 8] = d[b*8 +: 8];
        end
    endfunction

    function automatic logic [127:0] model_read(input logic [27:0] a);
        return model_mem[(int'(a) / 8) % 1024];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send_cmd(input logic [2:0] cmd, input logic [27:0] addr,
                            output int t, output bit ok);
        ok = 1'b0;
        t = -1;
        app_cmd = cmd;
        app_addr = addr;
        app_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (app_rdy === 1'b1) begin
                ok = 1'b1;
                t = cyc;
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        app_en = 1'b0;
    endtask

    task automatic send_wdf(input logic [127:0] d, input logic [15:0] m,
                            output bit ok);
        ok = 1'b0;
        app_wdf_data = d;
        app_wdf_mask = m;
        app_wdf_wren = 1'b1;
        app_wdf_end = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (app_wdf_rdy === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        app_wdf_wren = 1'b0;
        app_wdf_end = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 200; i++) begin
            if (rd_q.size() >= n) break;
            @(posedge clk);
            #1;
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int lows_r;
        int lows_w;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({app_rdy, app_wdf_rdy, app_rd_data_valid, init_calib_complete,
             err_cmd, err_wdf} !== 6'b0) begin
            $display("FAIL reset_outputs got %b want 000000",
                     {app_rdy, app_wdf_rdy, app_rd_data_valid,
                      init_calib_complete, err_cmd, err_wdf});
        end else passed++;
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (init_calib_complete !== (k >= 16)) begin
                $display("FAIL calib_k%0d got %b want %b", k,
                         init_calib_complete, k >= 16);
            end else passed++;
            if (k < 16) begin
                total++;
                if ({app_rdy, app_wdf_rdy} !== 2'b00) begin
                    $display("FAIL rdy_before_calib_k%0d got %b want 00",
                             k, {app_rdy, app_wdf_rdy});
                end else passed++;
            end
        end
        lows_r = 0;
        lows_w = 0;
        repeat (30) begin
            @(negedge clk);
            if (app_rdy !== 1'b1) lows_r++;
            if (app_wdf_rdy !== 1'b1) lows_w++;
        end
        @(posedge clk);
        #1;
        total++;
        if (lows_r !== 10) begin
            $display("FAIL rdy_stall_count got %0d want 10", lows_r);
        end else passed++;
        total++;
        if (lows_w !== 6) begin
            $display("FAIL wdf_stall_count got %0d want 6", lows_w);
        end else passed++;
    endtask

    task automatic test_single;
        bit ok_c;
        bit ok_d;
        int t;
        rd_q.delete();
        rd_c.delete();
        fork
            send_cmd(WR, 28'h40, t, ok_c);
            send_wdf(128'hA5, 16'h0, ok_d);
        join
        model_write(28'h40, 128'hA5, 16'h0);
        send_cmd(RD, 28'h40, t, ok_c);
        total++;
        if (!(ok_c && ok_d)) begin
            $display("FAIL single_accept got %b want 1", ok_c && ok_d);
        end else passed++;
        wait_beats(1);
        total++;
        if (rd_q.size() !== 1) begin
            $display("FAIL single_beats got %0d want 1", rd_q.size());
        end else begin
            passed++;
            total++;
            if (rd_q[0] !== model_read(28'h40)) begin
                $display("FAIL single_data got %h want %h", rd_q[0],
                         model_read(28'h40));
            end else passed++;
            total++;
            if (rd_c[0] !== t + RD_LAT) begin
                $display("FAIL single_latency got %0d want %0d", rd_c[0],
                         t + RD_LAT);
            end else passed++;
        end
    endtask

    task automatic test_data_first;
        logic [127:0] d;
        bit ok;
        int acc;
        int t;
        int ts[$];
        rd_q.delete();
        rd_c.delete();
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            d = rand128();
            send_wdf(d, 16'h0, ok);
            acc += int'(ok);
            model_write(28'(i * 8), d, 16'h0);
        end
        for (int i = 0; i < 3; i++) begin
            send_cmd(WR, 28'(i * 8), t, ok);
            acc += int'(ok);
        end
        app_cmd = RD;
        app_addr = 28'h0;
        app_en = 1'b1;
        @(negedge clk);
        total++;
        if (app_rdy !== 1'b0) begin
            $display("FAIL read_hazard got %b want 0", app_rdy);
        end else passed++;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            send_cmd(RD, 28'(i * 8), t, ok);
            acc += int'(ok);
            ts.push_back(t);
        end
        total++;
        if (acc !== 9) begin
            $display("FAIL data_first_accepts got %0d want 9", acc);
        end else passed++;
        wait_beats(3);
        total++;
        if (rd_q.size() !== 3) begin
            $display("FAIL data_first_beats got %0d want 3", rd_q.size());
        end else begin
            passed++;
            for (int i = 0; i < 3; i++) begin
                total++;
                if (rd_q[i] !== model_read(28'(i * 8)) ||
                    rd_c[i] !== ts[i] + RD_LAT) begin
                    $display("FAIL data_first_beat%0d got %h@%0d want %h@%0d",
                             i, rd_q[i], rd_c[i], model_read(28'(i * 8)),
                             ts[i] + RD_LAT);
                end else passed++;
            end
        end
    endtask

    task automatic test_mask;
        bit ok_c;
        bit ok_d;
        int t;
        rd_q.delete();
        rd_c.delete();
        fork
            send_cmd(WR, 28'h80, t, ok_c);
            send_wdf({128{1'b1}}, 16'h0, ok_d);
        join
        model_write(28'h80, {128{1'b1}}, 16'h0);
        fork
            send_cmd(WR, 28'h80, t, ok_c);
            send_wdf(128'h0, 16'hFFFE, ok_d);
        join
        model_write(28'h80, 128'h0, 16'hFFFE);
        send_cmd(RD, 28'h80, t, ok_c);
        wait_beats(1);
        total++;
        if (rd_q.size() !== 1) begin
            $display("FAIL mask_beats got %0d want 1", rd_q.size());
        end else begin
            passed++;
            total++;
            if (rd_q[0] !== model_read(28'h80)) begin
                $display("FAIL mask_data got %h want %h", rd_q[0],
                         model_read(28'h80));
            end else passed++;
        end
    endtask

    task automatic test_stress(output logic [27:0] base);
        logic [127:0] dq[8];
        logic [27:0] wa[3];
        int acc_c;
        int acc_d;
        int t;
        int ts[$];
        bit ok;
        rd_q.delete();
        rd_c.delete();
        base = 28'($urandom_range(16, 1000) * 8);
        for (int i = 0; i < 8; i++) dq[i] = rand128();
        acc_c = 0;
        acc_d = 0;
        fork
            for (int i = 0; i < 8; i++) begin
                int tc;
                bit okc;
                send_cmd(WR, base + 28'(i * 8), tc, okc);
                acc_c += int'(okc);
            end
            for (int j = 0; j < 8; j++) begin
                bit okd;
                send_wdf(dq[j], 16'h0, okd);
                acc_d += int'(okd);
            end
        join
        for (int i = 0; i < 8; i++) model_write(base + 28'(i * 8), dq[i], 16'h0);
        for (int i = 0; i < 8; i++) begin
            send_cmd(RD, base + 28'(i * 8), t, ok);
            ts.push_back(t);
        end
        total++;
        if (acc_c + acc_d !== 16) begin
            $display("FAIL stress_wr_accepts got %0d want 16", acc_c + acc_d);
        end else passed++;
        wait_beats(8);
        total++;
        if (rd_q.size() !== 8) begin
            $display("FAIL stress_beats got %0d want 8", rd_q.size());
        end else begin
            passed++;
            for (int i = 0; i < 8; i++) begin
                total++;
                if (rd_q[i] !== model_read(base + 28'(i * 8)) ||
                    rd_c[i] !== ts[i] + RD_LAT) begin
                    $display("FAIL stress_beat%0d got %h@%0d want %h@%0d", i,
                             rd_q[i], rd_c[i], model_read(base + 28'(i * 8)),
                             ts[i] + RD_LAT);
                end else passed++;
            end
        end
        rd_q.delete();
        rd_c.delete();
        wa[0] = 28'(1023 * 8);
        wa[1] = 28'(1024 * 8);
        wa[2] = 28'h0;
        for (int i = 0; i < 2; i++) begin
            logic [127:0] d;
            bit okc;
            bit okd;
            int tc;
            d = rand128();
            fork
                send_cmd(WR, wa[i], tc, okc);
                send_wdf(d, 16'h0, okd);
            join
            model_write(wa[i], d, 16'h0);
        end
        for (int i = 0; i < 3; i++) send_cmd(RD, wa[i], t, ok);
        wait_beats(3);
        total++;
        if (rd_q.size() !== 3) begin
            $display("FAIL wrap_beats got %0d want 3", rd_q.size());
        end else begin
            passed++;
            for (int i = 0; i < 3; i++) begin
                total++;
                if (rd_q[i] !== model_read(wa[i])) begin
                    $display("FAIL wrap_beat%0d got %h want %h", i, rd_q[i],
                             model_read(wa[i]));
                end else passed++;
            end
        end
    endtask

    task automatic test_reset_mid(input logic [27:0] base);
        int t;
        bit ok;
        for (int i = 0; i < 3; i++) send_cmd(RD, base + 28'(i * 8), t, ok);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd_q.delete();
        rd_c.delete();
        total++;
        if ({init_calib_complete, app_rdy, app_rd_data_valid} !== 3'b000) begin
            $display("FAIL midreset_outputs got %b want 000",
                     {init_calib_complete, app_rdy, app_rd_data_valid});
        end else passed++;
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (rd_q.size() !== 0) begin
            $display("FAIL midreset_dropped got %0d want 0", rd_q.size());
        end else passed++;
        total++;
        if (init_calib_complete !== 1'b1) begin
            $display("FAIL midreset_recalib got %b want 1", init_calib_complete);
        end else passed++;
        send_cmd(RD, base, t, ok);
        wait_beats(1);
        total++;
        if (rd_q.size() !== 1 || rd_q[0] !== model_read(base)) begin
            $display("FAIL midreset_ram_kept got %0d beats want 1 of %h",
                     rd_q.size(), model_read(base));
        end else passed++;
        total++;
        if ({err_cmd, err_wdf} !== 2'b00) begin
            $display("FAIL err_clear got %b want 00", {err_cmd, err_wdf});
        end else passed++;
        send_cmd(3'b010, 28'h0, t, ok);
        total++;
        if (!ok || err_cmd !== 1'b1) begin
            $display("FAIL err_cmd_set got acc=%b err=%b want 1 1", ok, err_cmd);
        end else passed++;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (err_cmd !== 1'b1 || err_wdf !== 1'b0) begin
            $display("FAIL err_cmd_sticky got %b%b want 10", err_cmd, err_wdf);
        end else passed++;
        app_wdf_wren = 1'b1;
        app_wdf_end = 1'b0;
        @(posedge clk);
        #1;
        app_wdf_wren = 1'b0;
        total++;
        if (err_wdf !== 1'b1) begin
            $display("FAIL err_wdf_set got %b want 1", err_wdf);
        end else passed++;
    endtask

    initial begin
        logic [27:0] base;
        rst_n = 1'b0;
        app_addr = '0;
        app_cmd = WR;
        app_en = 1'b0;
        app_wdf_data = '0;
        app_wdf_mask = '0;
        app_wdf_wren = 1'b0;
        app_wdf_end = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_data_first();
        test_mask();
        test_stress(base);
        test_reset_mid(base);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
